// File: rtl/gold_gen_ng.sv
// gold_gen_ng: gold-code chip generator built from two Fibonacci-style
// shift registers (A and B).
// The chip output is the XOR of the last stage of each register.
// The registers can be seeded in two ways:
//   - a serial fill, one bit per enabled cycle, controlled by Fill_En;
//   - a parallel load, controlled by Load_Req.
// A chip counter marks epoch boundaries, and a sticky flag reports a
// register that has collapsed to all-zero.
// Build option: define GOLD_AUTO_RESEED_EN to reload both registers from the
// captured seeds on every epoch wrap instead of free-running through it.

module gold_gen_ng #(
  parameter int LEN_A     = 26,
  parameter int TAP_A     = 21,
  parameter int LEN_B     = 26,
  parameter int TAP_B     = 23,
  parameter int EPOCH_LEN = 1023,
  localparam int CW       = $clog2(EPOCH_LEN)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Fill_En,
  input  logic             New_Fill_A,
  input  logic             New_Fill_B,
  input  logic             Load_Req,
  input  logic [LEN_A-1:0] Seed_A,
  input  logic [LEN_B-1:0] Seed_B,
  output logic             Load_Ack,
  output logic             Chip,
  output logic             Chip_Valid,
  output logic             Epoch,
  output logic             Zero_Err,
  output logic [CW-1:0]    Chip_Cnt
);

  // The fill is complete once the longer register has been fully replaced.
  localparam int FILL_MAX = (LEN_A > LEN_B) ? LEN_A : LEN_B;
  localparam int FW       = $clog2(FILL_MAX + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(EPOCH_LEN - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(FILL_MAX);
  localparam logic [FW-1:0] FILL_ONE  = FW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [LEN_A-1:0] a_reg, a_next, a_shift;
  logic [LEN_B-1:0] b_reg, b_next, b_shift;
  logic [LEN_A-1:0] hold_a_reg, hold_a_next;
  logic [LEN_B-1:0] hold_b_reg, hold_b_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [FW-1:0]    fill_reg, fill_next;
  logic             ack_reg, ack_next;
  logic             epoch_reg, epoch_next;
  logic             zero_reg, zero_next;

  logic a_in, b_in;
  logic fill_go, fill_stop, run_step, wrap_now, reseed_now;

  // Stage-0 input: the serial fill bit while filling, the feedback XOR otherwise.
  assign a_in = Fill_En ? New_Fill_A : (a_reg[LEN_A-1] ^ a_reg[TAP_A-1]);
  assign b_in = Fill_En ? New_Fill_B : (b_reg[LEN_B-1] ^ b_reg[TAP_B-1]);

  assign a_shift[0] = a_in;
  assign b_shift[0] = b_in;

  genvar gi;
  generate
    for (gi = 1; gi < LEN_A; gi++) begin : g_shift_a
      assign a_shift[gi] = a_reg[gi-1];
    end
    for (gi = 1; gi < LEN_B; gi++) begin : g_shift_b
      assign b_shift[gi] = b_reg[gi-1];
    end
  endgenerate

  // A load request overrides every other action in the same cycle.
  // Without Enable, only the load path can change state.
  assign fill_go   = Enable &  Fill_En & ~Load_Req;
  assign fill_stop = Enable & ~Fill_En & ~Load_Req & (state_reg == FILL);
  assign run_step  = Enable & ~Fill_En & ~Load_Req & (state_reg == RUN);
  assign wrap_now  = run_step & (cnt_reg == CNT_LAST);

`ifdef GOLD_AUTO_RESEED_EN
  assign reseed_now = wrap_now;
`else
  assign reseed_now = 1'b0;
`endif

  // Next-state and datapath decisions; all defaults hold state, pulses low.
  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    hold_a_next = hold_a_reg;
    hold_b_next = hold_b_reg;
    cnt_next    = cnt_reg;
    fill_next   = fill_reg;
    ack_next    = 1'b0;
    epoch_next  = 1'b0;
    zero_next   = zero_reg;

    if (Load_Req) begin
      a_next      = Seed_A;
      b_next      = Seed_B;
      hold_a_next = Seed_A;
      hold_b_next = Seed_B;
      cnt_next    = '0;
      state_next  = RUN;
      ack_next    = 1'b1;
      // A zero seed is flagged at once rather than one chip later.
      zero_next   = (Seed_A == '0) | (Seed_B == '0);
    end else if (fill_go) begin
      state_next = FILL;
      a_next     = a_shift;
      b_next     = b_shift;
      if (state_reg != FILL) begin
        // The entry edge already shifts in the first fill bit.
        fill_next = FILL_ONE;
      end else if (fill_reg != FILL_FULL) begin
        fill_next = fill_reg + 1'b1;
      end
    end else if (fill_stop) begin
      if (fill_reg >= FILL_FULL) begin
        state_next = RUN;
        cnt_next   = '0;
      end else begin
        state_next = IDLE;
      end
    end else if (run_step) begin
      zero_next = zero_reg | (a_reg == '0) | (b_reg == '0);
      if (reseed_now) begin
        a_next = hold_a_reg;
        b_next = hold_b_reg;
      end else begin
        a_next = a_shift;
        b_next = b_shift;
      end
      if (wrap_now) begin
        cnt_next   = '0;
        epoch_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // State register with asynchronous reset; reset also blocks load and fill.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      hold_a_reg <= '0;
      hold_b_reg <= '0;
      cnt_reg    <= '0;
      fill_reg   <= '0;
      ack_reg    <= 1'b0;
      epoch_reg  <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      hold_a_reg <= hold_a_next;
      hold_b_reg <= hold_b_next;
      cnt_reg    <= cnt_next;
      fill_reg   <= fill_next;
      ack_reg    <= ack_next;
      epoch_reg  <= epoch_next;
      zero_reg   <= zero_next;
    end
  end

  assign Chip       = a_reg[LEN_A-1] ^ b_reg[LEN_B-1];
  assign Chip_Valid = (state_reg == RUN);
  assign Chip_Cnt   = cnt_reg;
  assign Load_Ack   = ack_reg;
  assign Epoch      = epoch_reg;
  assign Zero_Err   = zero_reg;

endmodule

// File: tb/tb_gold_gen_ng.sv
// tb_gold_gen_ng: directed tests for gold_gen_ng, with hand-computed expected values.
// Two instances are used: one with the default parameters, and one with an
// 8-chip epoch for the wrap and reseed cases.

module tb_gold_gen_ng;

`ifdef GOLD_AUTO_RESEED_EN
  localparam bit RESEED = 1'b1;
`else
  localparam bit RESEED = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset, Enable, Fill_En, New_Fill_A, New_Fill_B, Load_Req;
  logic [25:0] Seed_A, Seed_B, Seed_A8, Seed_B8;

  logic        Load_Ack, Chip, Chip_Valid, Epoch, Zero_Err;
  logic [9:0]  Chip_Cnt;
  logic        Load_Ack8, Chip8, Chip_Valid8, Epoch8, Zero_Err8;
  logic [2:0]  Chip_Cnt8;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  gold_gen_ng dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Fill_En(Fill_En),
    .New_Fill_A(New_Fill_A), .New_Fill_B(New_Fill_B), .Load_Req(Load_Req),
    .Seed_A(Seed_A), .Seed_B(Seed_B), .Load_Ack(Load_Ack), .Chip(Chip),
    .Chip_Valid(Chip_Valid), .Epoch(Epoch), .Zero_Err(Zero_Err),
    .Chip_Cnt(Chip_Cnt)
  );

  gold_gen_ng #(.EPOCH_LEN(8)) dut8 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Fill_En(Fill_En),
    .New_Fill_A(New_Fill_A), .New_Fill_B(New_Fill_B), .Load_Req(Load_Req),
    .Seed_A(Seed_A8), .Seed_B(Seed_B8), .Load_Ack(Load_Ack8), .Chip(Chip8),
    .Chip_Valid(Chip_Valid8), .Epoch(Epoch8), .Zero_Err(Zero_Err8),
    .Chip_Cnt(Chip_Cnt8)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Enable = 1'b0; Fill_En = 1'b0; Load_Req = 1'b0;
    New_Fill_A = 1'b0; New_Fill_B = 1'b0;
    Seed_A = '0; Seed_B = '0; Seed_A8 = '0; Seed_B8 = '0;

    // Reset state
    tick();
    check_val("rst_chip",  Chip, 0);
    check_val("rst_valid", Chip_Valid, 0);
    check_val("rst_ack",   Load_Ack, 0);
    check_val("rst_epoch", Epoch, 0);
    check_val("rst_zero",  Zero_Err, 0);
    check_val("rst_cnt",   Chip_Cnt, 0);
    Reset = 1'b0;

    // Load A=1, B=2: the B bit reaches the top stage first, after 24 chips
    Seed_A = 26'd1; Seed_B = 26'd2;
    Seed_A8 = 26'h2000000; Seed_B8 = 26'd1;
    Load_Req = 1'b1; Enable = 1'b1;
    tick();
    Load_Req = 1'b0;
    check_val("ld_ack",   Load_Ack, 1);
    check_val("ld_valid", Chip_Valid, 1);
    check_val("ld_cnt",   Chip_Cnt, 0);
    check_val("ld_chip0", Chip, 0);
    check_val("ld_zero",  Zero_Err, 0);
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (n == 1) check_val("ld_ack_drop", Load_Ack, 0);
      check_val($sformatf("seq_cnt%0d", n), Chip_Cnt, n);
      check_val($sformatf("seq_chip%0d", n), Chip, (n == 24) ? 1 : 0);
    end

    // Enable low freezes everything
    Enable = 1'b0;
    tick();
    tick();
    check_val("frz_cnt",  Chip_Cnt, 24);
    check_val("frz_chip", Chip, 1);

    // Serial fill: 10 bits fall back to IDLE, 26 bits reach RUN
    pulse_reset();
    Seed_A = 26'd1; Seed_B = 26'd2; Load_Req = 1'b1; Enable = 1'b1;
    tick();
    Load_Req = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    check_val("pre_fill_cnt", Chip_Cnt, 5);
    Fill_En = 1'b1; New_Fill_A = 1'b1; New_Fill_B = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    check_val("fill10_valid", Chip_Valid, 0);
    check_val("fill10_cnt",   Chip_Cnt, 5);
    Fill_En = 1'b0;
    tick();
    check_val("short_valid", Chip_Valid, 0);
    check_val("short_cnt",   Chip_Cnt, 5);
    tick();
    check_val("idle_cnt", Chip_Cnt, 5);
    Fill_En = 1'b1;
    for (int n = 0; n < 26; n++) tick();
    Fill_En = 1'b0;
    tick();
    check_val("full_valid", Chip_Valid, 1);
    check_val("full_cnt",   Chip_Cnt, 0);
    check_val("full_chip",  Chip, 1);
    check_val("full_zero0", Zero_Err, 0);
    tick();
    check_val("run_cnt1",   Chip_Cnt, 1);
    check_val("run_chip1",  Chip, 1);
    check_val("full_zero1", Zero_Err, 1);

    // Load_Req and Fill_En together: the load wins; held Load_Req acks every cycle
    Seed_A = 26'd1; Seed_B = 26'd2; Load_Req = 1'b1; Fill_En = 1'b1;
    tick();
    check_val("pri_ack",   Load_Ack, 1);
    check_val("pri_valid", Chip_Valid, 1);
    check_val("pri_cnt",   Chip_Cnt, 0);
    check_val("pri_zero",  Zero_Err, 0);
    tick();
    check_val("hold_ack", Load_Ack, 1);
    check_val("hold_cnt", Chip_Cnt, 0);
    Load_Req = 1'b0; Fill_En = 1'b0;
    tick();
    check_val("rel_ack",   Load_Ack, 0);
    check_val("rel_cnt",   Chip_Cnt, 1);
    check_val("rel_valid", Chip_Valid, 1);

    // Zero seed raises a sticky error, cleared only by a fresh load
    Seed_A = 26'd0; Seed_B = 26'd5; Load_Req = 1'b1;
    tick();
    Load_Req = 1'b0;
    check_val("zs_ack",  Load_Ack, 1);
    check_val("zs_zero", Zero_Err, 1);
    for (int n = 0; n < 3; n++) tick();
    check_val("zs_sticky", Zero_Err, 1);
    Seed_A = 26'd1; Seed_B = 26'd2; Load_Req = 1'b1;
    tick();
    Load_Req = 1'b0;
    check_val("zs_clear", Zero_Err, 0);
    tick();
    check_val("zs_stay0", Zero_Err, 0);

    // 8-chip epoch: Epoch pulses every 8 chips; with reseed, the Chip pattern repeats
    pulse_reset();
    Load_Req = 1'b1;
    tick();
    Load_Req = 1'b0;
    check_val("ep_chip0",  Chip8, 1);
    check_val("ep_cnt0",   Chip_Cnt8, 0);
    check_val("ep_epoch0", Epoch8, 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_val($sformatf("ep_epoch%0d", k), Epoch8, (k % 8 == 0) ? 1 : 0);
      check_val($sformatf("ep_cnt%0d", k), Chip_Cnt8, k % 8);
      check_val($sformatf("ep_chip%0d", k), Chip8, ((k % 8 == 0) && RESEED) ? 1 : 0);
    end

    // Asynchronous reset asserted between clock edges while in RUN
    Seed_A = 26'h2000000; Seed_B = 26'd0; Load_Req = 1'b1;
    tick();
    Load_Req = 1'b0;
    check_val("ar_pre_ack",   Load_Ack, 1);
    check_val("ar_pre_chip",  Chip, 1);
    check_val("ar_pre_valid", Chip_Valid, 1);
    check_val("ar_pre_zero",  Zero_Err, 1);
    #3;
    Reset = 1'b1;
    #1;
    check_val("ar_chip",  Chip, 0);
    check_val("ar_valid", Chip_Valid, 0);
    check_val("ar_ack",   Load_Ack, 0);
    check_val("ar_zero",  Zero_Err, 0);
    check_val("ar_epoch", Epoch, 0);
    check_val("ar_cnt",   Chip_Cnt, 0);
    Load_Req = 1'b1; Fill_En = 1'b1;
    tick();
    check_val("ar_ign_valid", Chip_Valid, 0);
    check_val("ar_ign_ack",   Load_Ack, 0);
    Load_Req = 1'b0; Fill_En = 1'b0;
    Reset = 1'b0;
    tick();
    check_val("ar_idle_valid", Chip_Valid, 0);
    check_val("ar_idle_chip",  Chip, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gold_gen_ng.md
GOLD_GEN_NG -- requirements
Module: gold_gen_ng

Interface
REQ-001 SHALL have parameter LEN_A, default 26, meaning register A length (≥3).
REQ-002 SHALL have parameter TAP_A, default 21, meaning register A inner feedback tap stage count (2..LEN_A-1).
REQ-003 SHALL have parameter LEN_B, default 26, meaning register B length (≥3).
REQ-004 SHALL have parameter TAP_B, default 23, meaning register B inner feedback tap stage count (2..LEN_B-1).
REQ-005 SHALL have parameter EPOCH_LEN, default 1023, meaning chips per epoch (≥2); CW = clog2(EPOCH_LEN).
REQ-006 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port Enable, input, 1 bit: chip-advance qualifier for shifting and counting.
REQ-009 SHALL have ports Fill_En, New_Fill_A, New_Fill_B, inputs, 1 bit each: serial fill enable and fill data per register.
REQ-010 SHALL have port Load_Req, input, 1 bit: parallel seed load request.
REQ-011 SHALL have ports Seed_A [LEN_A-1:0] and Seed_B [LEN_B-1:0], inputs: parallel seeds, bit i loads stage i.
REQ-012 SHALL have port Load_Ack, output, 1 bit: one-cycle acknowledge of a seed load.
REQ-013 SHALL have port Chip, output, 1 bit: gold chip = A[LEN_A-1] ^ B[LEN_B-1].
REQ-014 SHALL have ports Chip_Valid, Epoch, Zero_Err, outputs, 1 bit each; and Chip_Cnt, output, CW bits.

Function
REQ-015 SHALL shift each register on an Enable edge as stage[k] <= stage[k-1]; stage[0] <= (Fill_En ? New_Fill_x : stage[LEN-1] ^ stage[TAP-1]).
REQ-016 SHALL implement FSM states IDLE, FILL, RUN.
REQ-017 SHALL, in IDLE, hold registers; Chip_Valid=0.
REQ-018 SHALL enter FILL from IDLE or RUN on Enable & Fill_En & !Load_Req; in FILL, count filled bits (saturating at max(LEN_A,LEN_B)).
REQ-019 SHALL, when Fill_En deasserts in FILL, go to RUN if fill count ≥ max(LEN_A,LEN_B), else to IDLE.
REQ-020 SHALL, on Load_Req high at an edge, irrespective of Enable and state, load Seed_A/Seed_B, capture both seeds into seed-hold registers, clear Chip_Cnt, and enter RUN.
REQ-021 SHALL assert Load_Ack for exactly the cycle following the accepting edge; Load_Req held high reloads every cycle and acks every cycle.
REQ-022 SHALL give Load_Req priority over Fill_En in the same cycle.
REQ-023 SHALL assert Chip_Valid only in RUN.
REQ-024 SHALL make Chip of the seeds visible the cycle after load (zero added latency beyond the register).
REQ-025 SHALL increment Chip_Cnt on each Enable edge in RUN, wrapping EPOCH_LEN-1 -> 0; Chip_Cnt holds in IDLE/FILL and clears on FILL->RUN.
REQ-026 SHALL pulse Epoch for one cycle after the edge on which Chip_Cnt wraps.
REQ-027 SHALL set sticky Zero_Err when, in RUN, either register is all-zero; cleared only by Reset or an accepted load.
REQ-028 SHALL freeze all state when Enable=0, except load handling.

Reset
REQ-029 SHALL, on Reset high (asynchronous, mid-operation included), clear both registers, seed-hold registers, Chip_Cnt and fill count; go to IDLE; drive Chip=0, Chip_Valid=0, Epoch=0, Load_Ack=0, Zero_Err=0.
REQ-030 SHALL ignore Load_Req and Fill_En while Reset is high.

Configuration
REQ-031 SHALL support macro GOLD_AUTO_RESEED_EN: when defined, on the Chip_Cnt wrap edge both registers reload from seed-hold registers instead of shifting (no Load_Ack).
REQ-032 SHALL, without GOLD_AUTO_RESEED_EN, shift free-running through the wrap; seed-hold registers remain present and unused.

Verification
REQ-033 SHALL cover: Reset, Seed_A=1, Seed_B=2, Load_Req one cycle, Enable=1 -> Load_Ack one cycle, Chip=0 at Chip_Cnt 0..23, Chip=1 at Chip_Cnt=24.
REQ-034 SHALL cover: Fill_En for 10 Enable cycles then drop -> IDLE, Chip_Valid=0; Fill_En for 26 cycles then drop -> RUN, Chip_Valid=1, Chip_Cnt=0.
REQ-035 SHALL cover: EPOCH_LEN=8, loaded, Enable=1 -> Epoch pulses every 8 cycles; with GOLD_AUTO_RESEED_EN the Chip sequence repeats every 8 chips.
REQ-036 SHALL cover: Load_Req and Fill_En both high -> load taken, state RUN, Load_Ack=1.
REQ-037 SHALL cover: Seed_A=0, Seed_B=5, load -> Zero_Err=1 next cycle and stays set until a new load with nonzero seeds.
REQ-038 SHALL cover: Reset asserted mid-RUN between edges -> all outputs 0 immediately, state IDLE.
